// File: rtl/ret_stack.sv
// Hardware return-address stack for the program counter.
// A call pushes the current return address. A return pops the top entry and
// hands it back to the PC as a one-cycle registered load/data pair.
// The stack keeps sticky overflow and underflow flags for debug.
module ret_stack #(
    parameter int NBITS  = 8,
    parameter int SDEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [NBITS-1:0]  pc_in,
    output logic              ret_load,
    output logic [NBITS-1:0]  ret_addr,
    output logic [SDEPTH:0]   level,
    output logic              empty,
    output logic              full,
    output logic              ovf,
    output logic              unf
);

    localparam int DEPTH = 2 ** SDEPTH;

    // level is one bit wider than the index so that DEPTH itself is representable
    localparam logic [SDEPTH:0] LVL_ONE   = (SDEPTH + 1)'(1);
    localparam logic [SDEPTH:0] LVL_DEPTH = (SDEPTH + 1)'(DEPTH);

    // Architectural state
    logic [NBITS-1:0]  mem_q [DEPTH];
    logic [SDEPTH:0]   level_q,    level_d;
    logic              ret_load_q, ret_load_d;
    logic [NBITS-1:0]  ret_addr_q, ret_addr_d;
    logic              ovf_q,      ovf_d;
    logic              unf_q,      unf_d;

    // Storage write port, computed together with the next state
    logic              wr_en;
    logic [SDEPTH-1:0] wr_idx;
    logic [NBITS-1:0]  wr_data;

    // Slot indices derived from the occupancy count
    logic [SDEPTH-1:0] top_idx;
    logic [SDEPTH-1:0] free_idx;
    logic              is_empty;
    logic              is_full;

    assign is_empty = (level_q == '0);
    assign is_full  = (level_q == LVL_DEPTH);

    // The top slot is level-1. When level is DEPTH the low bits wrap to the last
    // slot, which is exactly the top; when level is 0 the index is never used.
    assign top_idx  = SDEPTH'(level_q - LVL_ONE);
    assign free_idx = level_q[SDEPTH-1:0];

    // Next-state decode of the push/pop strobes against the current occupancy
    always_comb begin
        level_d    = level_q;
        ret_load_d = 1'b0;
        ret_addr_d = ret_addr_q;
        ovf_d      = ovf_q;
        unf_d      = unf_q;
        wr_en      = 1'b0;
        wr_idx     = free_idx;
        wr_data    = pc_in;

        case ({push, pop})
            2'b10: begin
                // call: store into the next free slot unless the stack is full
                if (!is_full) begin
                    wr_en   = 1'b1;
                    wr_idx  = free_idx;
                    level_d = level_q + LVL_ONE;
                end else begin
                    ovf_d = 1'b1;
                end
            end
            2'b01: begin
                // return: hand back the top entry unless there is nothing to pop
                if (!is_empty) begin
                    ret_addr_d = mem_q[top_idx];
                    ret_load_d = 1'b1;
                    level_d    = level_q - LVL_ONE;
                end else begin
                    unf_d = 1'b1;
                end
            end
            2'b11: begin
                // return and call in the same cycle: the new address replaces the
                // old top, so depth is unchanged; on an empty stack it bypasses
                ret_load_d = 1'b1;
                if (!is_empty) begin
                    ret_addr_d = mem_q[top_idx];
                    wr_en      = 1'b1;
                    wr_idx     = top_idx;
                end else begin
                    ret_addr_d = pc_in;
                end
            end
            default: begin
                ret_load_d = 1'b0;
            end
        endcase
    end

    // Control and output registers, cleared asynchronously by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_q    <= '0;
            ret_load_q <= 1'b0;
            ret_addr_q <= '0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
        end else begin
            level_q    <= level_d;
            ret_load_q <= ret_load_d;
            ret_addr_q <= ret_addr_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
        end
    end

    // Storage array is not reset; stale entries are unreachable once level is 0
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_idx] <= wr_data;
        end
    end

    assign ret_load = ret_load_q;
    assign ret_addr = ret_addr_q;
    assign level    = level_q;
    assign empty    = is_empty;
    assign full     = is_full;
    assign ovf      = ovf_q;
    assign unf      = unf_q;

endmodule

// File: tb/tb_ret_stack.sv
// Self-checking bench for ret_stack using a queue-based LIFO reference model.
module tb_ret_stack;

    localparam int NBITS  = 8;
    localparam int SDEPTH = 4;
    localparam int DEPTH  = 16;

    logic              clk;
    logic              rst;
    logic              push;
    logic              pop;
    logic [NBITS-1:0]  pc_in;
    logic              ret_load;
    logic [NBITS-1:0]  ret_addr;
    logic [SDEPTH:0]   level;
    logic              empty;
    logic              full;
    logic              ovf;
    logic              unf;

    int checks = 0;
    int errors = 0;

    // Reference model: a queue whose back is the top of stack
    logic [NBITS-1:0]  model_q [$];
    logic              m_ovf;
    logic              m_unf;
    logic              m_load;
    logic [NBITS-1:0]  m_addr;

    ret_stack #(.NBITS(NBITS), .SDEPTH(SDEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .pop      (pop),
        .pc_in    (pc_in),
        .ret_load (ret_load),
        .ret_addr (ret_addr),
        .level    (level),
        .empty    (empty),
        .full     (full),
        .ovf      (ovf),
        .unf      (unf)
    );

    // Free-running clock, period 10
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic model_reset();
        model_q.delete();
        m_ovf  = 1'b0;
        m_unf  = 1'b0;
        m_load = 1'b0;
        m_addr = '0;
    endtask

    // Drive one cycle of strobes, advance past the edge, then update the model
    task automatic do_cycle(input logic p, input logic o, input logic [NBITS-1:0] d);
        push  = p;
        pop   = o;
        pc_in = d;
        @(posedge clk);
        #1;
        m_load = 1'b0;
        if (p && o) begin
            m_load = 1'b1;
            if (model_q.size() == 0) begin
                m_addr = d;
            end else begin
                m_addr = model_q[$];
                model_q[$] = d;
            end
        end else if (p) begin
            if (model_q.size() < DEPTH) model_q.push_back(d);
            else m_ovf = 1'b1;
        end else if (o) begin
            if (model_q.size() > 0) begin
                m_addr = model_q.pop_back();
                m_load = 1'b1;
            end else begin
                m_unf = 1'b1;
            end
        end
        push  = 1'b0;
        pop   = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; push = 1'b0; pop = 1'b0; pc_in = '0;
        model_reset();
        #3;
        checks++;
        if (level !== '0 || empty !== 1'b1 || full !== 1'b0 || ret_load !== 1'b0 ||
            ret_addr !== '0 || ovf !== 1'b0 || unf !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_values: level=%0d empty=%b full=%b load=%b addr=%h ovf=%b unf=%b, required 0 1 0 0 00 0 0",
                     level, empty, full, ret_load, ret_addr, ovf, unf);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        // Reset asserted mid-cycle with no clock edge must act immediately
        do_cycle(1'b1, 1'b0, 8'h11);
        do_cycle(1'b1, 1'b0, 8'h22);
        do_cycle(1'b0, 1'b1, 8'h00);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (level !== '0 || empty !== 1'b1 || ret_load !== 1'b0 || ret_addr !== '0) begin
            errors++;
            $display("[TB] FAIL async_reset: level=%0d empty=%b load=%b addr=%h, required 0 1 0 00",
                     level, empty, ret_load, ret_addr);
        end
        rst = 1'b0;
        model_reset();
        do_cycle(1'b0, 1'b0, 8'h00);
        checks++;
        if (level !== '0) begin
            errors++;
            $display("[TB] FAIL reset_release_level: got %0d, required 0", level);
        end
    endtask

    task automatic test_lifo();
        logic [NBITS-1:0] vals [3];
        vals[0] = 8'h10; vals[1] = 8'h20; vals[2] = 8'h30;
        for (int i = 0; i < 3; i++) do_cycle(1'b1, 1'b0, vals[i]);
        checks++;
        if (level !== 5'd3) begin
            errors++;
            $display("[TB] FAIL lifo_level: got %0d, required 3", level);
        end
        for (int i = 2; i >= 0; i--) begin
            do_cycle(1'b0, 1'b1, 8'h00);
            checks++;
            if (ret_load !== 1'b1 || ret_addr !== vals[i]) begin
                errors++;
                $display("[TB] FAIL lifo_pop%0d: load=%b addr=%h, required 1 %h", 2 - i, ret_load, ret_addr, vals[i]);
            end
        end
        do_cycle(1'b0, 1'b0, 8'h00);
        checks++;
        if (ret_load !== 1'b0 || level !== '0 || empty !== 1'b1) begin
            errors++;
            $display("[TB] FAIL lifo_end: load=%b level=%0d empty=%b, required 0 0 1", ret_load, level, empty);
        end
    endtask

    task automatic test_overflow();
        for (int i = 1; i <= DEPTH; i++) do_cycle(1'b1, 1'b0, NBITS'(i));
        checks++;
        if (full !== 1'b1 || ovf !== 1'b0 || level !== 5'd16) begin
            errors++;
            $display("[TB] FAIL ovf_fill: full=%b ovf=%b level=%0d, required 1 0 16", full, ovf, level);
        end
        do_cycle(1'b1, 1'b0, 8'hAA);
        checks++;
        if (ovf !== 1'b1 || level !== 5'd16) begin
            errors++;
            $display("[TB] FAIL ovf_push17: ovf=%b level=%0d, required 1 16", ovf, level);
        end
        for (int i = DEPTH; i >= 1; i--) begin
            do_cycle(1'b0, 1'b1, 8'h00);
            checks++;
            if (ret_load !== 1'b1 || ret_addr !== NBITS'(i)) begin
                errors++;
                $display("[TB] FAIL ovf_drain: load=%b addr=%h, required 1 %h", ret_load, ret_addr, NBITS'(i));
            end
        end
        checks++;
        if (empty !== 1'b1 || ovf !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ovf_sticky: empty=%b ovf=%b, required 1 1", empty, ovf);
        end
    endtask

    task automatic test_underflow();
        do_cycle(1'b0, 1'b1, 8'h00);
        checks++;
        if (ret_load !== 1'b0 || unf !== 1'b1 || ret_addr !== 8'h01) begin
            errors++;
            $display("[TB] FAIL unf_pop_empty: load=%b unf=%b addr=%h, required 0 1 01", ret_load, unf, ret_addr);
        end
        do_cycle(1'b1, 1'b0, 8'h42);
        do_cycle(1'b0, 1'b1, 8'h00);
        checks++;
        if (ret_load !== 1'b1 || ret_addr !== 8'h42 || unf !== 1'b1 || level !== '0) begin
            errors++;
            $display("[TB] FAIL unf_recover: load=%b addr=%h unf=%b level=%0d, required 1 42 1 0",
                     ret_load, ret_addr, unf, level);
        end
    endtask

    task automatic test_simultaneous();
        do_cycle(1'b1, 1'b0, 8'h05);
        do_cycle(1'b1, 1'b0, 8'h07);
        do_cycle(1'b1, 1'b1, 8'h09);
        checks++;
        if (ret_load !== 1'b1 || ret_addr !== 8'h07 || level !== 5'd2) begin
            errors++;
            $display("[TB] FAIL simul_replace: load=%b addr=%h level=%0d, required 1 07 2", ret_load, ret_addr, level);
        end
        do_cycle(1'b0, 1'b1, 8'h00);
        checks++;
        if (ret_load !== 1'b1 || ret_addr !== 8'h09) begin
            errors++;
            $display("[TB] FAIL simul_next_pop: load=%b addr=%h, required 1 09", ret_load, ret_addr);
        end
        do_cycle(1'b0, 1'b1, 8'h00);
        do_cycle(1'b1, 1'b1, 8'h3C);
        checks++;
        if (ret_load !== 1'b1 || ret_addr !== 8'h3C || level !== '0) begin
            errors++;
            $display("[TB] FAIL simul_bypass: load=%b addr=%h level=%0d, required 1 3c 0", ret_load, ret_addr, level);
        end
    endtask

    task automatic test_reset_during_pop();
        do_cycle(1'b1, 1'b0, 8'h55);
        do_cycle(1'b0, 1'b1, 8'h00);
        checks++;
        if (ret_load !== 1'b1 || ret_addr !== 8'h55) begin
            errors++;
            $display("[TB] FAIL rstpop_pulse: load=%b addr=%h, required 1 55", ret_load, ret_addr);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (ret_load !== 1'b0 || ret_addr !== '0) begin
            errors++;
            $display("[TB] FAIL rstpop_kill: load=%b addr=%h, required 0 00", ret_load, ret_addr);
        end
        rst = 1'b0;
        model_reset();
        do_cycle(1'b0, 1'b0, 8'h00);
        checks++;
        if (level !== '0 || ovf !== 1'b0 || unf !== 1'b0 || empty !== 1'b1) begin
            errors++;
            $display("[TB] FAIL rstpop_after: level=%0d ovf=%b unf=%b empty=%b, required 0 0 0 1",
                     level, ovf, unf, empty);
        end
    endtask

    task automatic test_random();
        logic             p;
        logic             o;
        logic [NBITS-1:0] d;
        logic [SDEPTH:0]  exp_level;
        int               r;
        for (int i = 0; i < 600; i++) begin
            r = $urandom_range(0, 9);
            // Alternate push-heavy and pop-heavy phases to reach both limits
            if (((i / 60) % 2) == 0) begin
                p = (r < 7);
                o = (r >= 5);
            end else begin
                p = (r >= 7);
                o = (r < 6) || (r == 9);
            end
            d = NBITS'($urandom_range(0, 255));
            do_cycle(p, o, d);
            exp_level = (SDEPTH + 1)'(model_q.size());
            checks++;
            if (level !== exp_level || empty !== (model_q.size() == 0) || full !== (model_q.size() == DEPTH)) begin
                errors++;
                $display("[TB] FAIL rand_level[%0d]: level=%0d empty=%b full=%b, required %0d %b %b",
                         i, level, empty, full, exp_level, model_q.size() == 0, model_q.size() == DEPTH);
            end
            checks++;
            if (ret_load !== m_load || ret_addr !== m_addr) begin
                errors++;
                $display("[TB] FAIL rand_ret[%0d]: load=%b addr=%h, required %b %h", i, ret_load, ret_addr, m_load, m_addr);
            end
            checks++;
            if (ovf !== m_ovf || unf !== m_unf) begin
                errors++;
                $display("[TB] FAIL rand_flags[%0d]: ovf=%b unf=%b, required %b %b", i, ovf, unf, m_ovf, m_unf);
            end
        end
    endtask

    initial begin
        test_reset();
        test_lifo();
        test_overflow();
        test_underflow();
        test_simultaneous();
        test_reset_during_pop();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ret_stack.md
Name: ret_stack

Overview:
- Hardware return-address stack paired with the program counter.
- On a call, it captures the current return address. On a return, it hands that address back to the PC as a registered load/data pair.
- It is the consumer and producer at the other end of the PC's load/data/addr path; the instruction decoder drives push/pop.
- One clock domain; asynchronous active-high reset.

Parameters:
- NBITS, 8, address width; matches the PC address width.
- SDEPTH, 4, log2 of stack depth; DEPTH = 2**SDEPTH entries (16 by default).

Ports:
- clk  input  1  system clock, rising-edge active.
- rst  input  1  asynchronous, active-high reset.
- push  input  1  call strobe: store pc_in on this clock edge.
- pop  input  1  return strobe: retrieve the top entry.
- pc_in  input  NBITS  return address to store; driven from the PC addr output.
- ret_load  output  1  one-cycle pulse to the PC load input.
- ret_addr  output  NBITS  return address to the PC data input; valid while ret_load=1.
- level  output  SDEPTH+1  number of occupied entries, 0..DEPTH.
- empty  output  1  level==0, combinational from level.
- full  output  1  level==DEPTH, combinational from level.
- ovf  output  1  sticky overflow flag.
- unf  output  1  sticky underflow flag.

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is asynchronous and active-high.
- Reset values: level=0, ret_load=0, ret_addr=0, ovf=0, unf=0, empty=1, full=0. Storage RAM is not reset; its contents are don't-care.
- Storage: DEPTH x NBITS register array, indexed by level (write slot) and level-1 (top).
- Latency: pop sampled at edge N gives ret_load=1 and ret_addr=popped value in the cycle after edge N, for exactly one cycle. ret_addr holds its last value when ret_load=0.
- push only, not full: mem[level] <= pc_in; level <= level+1.
- push only, full: write dropped; level unchanged; ovf <= 1.
- pop only, not empty: ret_addr <= mem[level-1]; ret_load <= 1; level <= level-1.
- pop only, empty: ret_load stays 0; ret_addr unchanged; unf <= 1.
- push and pop together, not empty (includes full):
  - ret_addr <= old top; ret_load <= 1.
  - mem[level-1] <= pc_in (replace); level unchanged.
  - No ovf or unf.
- push and pop together, empty (bypass):
  - ret_addr <= pc_in; ret_load <= 1.
  - level stays 0; nothing stored; no unf.
- Neither asserted: level and storage hold; ret_load <= 0.
- Sticky flags: ovf and unf clear only on rst.
- Width rules: level is unsigned, SDEPTH+1 bits, and never wraps. It saturates logically at 0 and DEPTH, because the guarded cases above block the increment and decrement.
- Reset mid-operation: rst asserted in any cycle immediately forces all outputs to their reset values, including a ret_load pulse in flight. After release, the stack is empty. Entries pushed before reset are unreachable.
- No combinational path from push/pop/pc_in to ret_load or ret_addr; all outputs come from registers. empty and full are decoded from the level register.

Test Plan:
- Reset: assert rst mid-cycle with no clock edge -> all outputs at reset values immediately; empty=1, level=0.
- LIFO order (NBITS=8):
  - Push 0x10, 0x20, 0x30 on consecutive cycles -> level=3.
  - Then pop three cycles -> ret_load pulses with ret_addr 0x30, 0x20, 0x10, each one cycle after its pop.
  - Level ends at 0 with empty=1.
- Overflow (SDEPTH=4):
  - Push 0x01..0x10 (16 pushes) -> full=1, ovf=0.
  - 17th push of 0xAA -> ovf=1, level=16.
  - 16 pops -> return 0x10 down to 0x01; 0xAA never appears.
- Underflow: pop while empty -> ret_load stays 0, unf=1. A later push/pop pair works normally, and unf stays 1.
- Simultaneous:
  - Stack holds [0x05, 0x07 top]; push 0x09 with pop -> ret_addr=0x07, level=2; next pop returns 0x09.
  - From empty, push 0x3C with pop -> ret_load=1, ret_addr=0x3C, level=0.
- Reset during a pop: pop at edge N, rst asserted before edge N+1 -> ret_load forced to 0. After release, level=0 and flags are 0.
